// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bin_to_bcd_seq : sequential double-dabble converter, binary -> 4 BCD     |
// | digits with atomic registered digit update. Optional: BCD_OVF_BLANK_EN   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bin_to_bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       units,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands,
  output logic             ovf
);

  localparam int c_CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [15:0]        r_scr;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_ovf_next;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic [3:0]         r_units;
  logic [3:0]         r_tens;
  logic [3:0]         r_hundreds;
  logic [3:0]         r_thousands;

  logic               w_ovf_in;
  logic [3:0]         w_adj_u;
  logic [3:0]         w_adj_t;
  logic [3:0]         w_adj_h;
  logic [2:0]         w_adj_th;
  logic [15:0]        w_scr_next;

  function automatic logic [3:0] f_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign w_adj_u  = f_adj(r_scr[3:0]);
  assign w_adj_t  = f_adj(r_scr[7:4]);
  assign w_adj_h  = f_adj(r_scr[11:8]);
  // Only the low 3 bits of the adjusted thousands nibble survive the shift.
  assign w_adj_th = r_scr[14:12] + ((r_scr[15:12] >= 4'd5) ? 3'd3 : 3'd0);

  assign w_scr_next = {w_adj_th, w_adj_h, w_adj_t, w_adj_u, r_bin[BIN_W-1]};

  generate
    if (BIN_W > 13) begin : g_ovf_cmp
      assign w_ovf_in = (bin_in > BIN_W'(9999));
    end else begin : g_ovf_none
      assign w_ovf_in = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_scr       <= '0;
      r_cnt       <= '0;
      r_ovf_next  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_units     <= 4'd0;
      r_tens      <= 4'd0;
      r_hundreds  <= 4'd0;
      r_thousands <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin      <= bin_in;
            r_scr      <= '0;
            r_cnt      <= c_CNT_W'(BIN_W);
            r_ovf_next <= w_ovf_in;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scr <= w_scr_next;
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_CNT_W'(1)) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
`ifdef BCD_OVF_BLANK_EN
          if (r_ovf_next) begin
            r_units     <= 4'hF;
            r_tens      <= 4'hF;
            r_hundreds  <= 4'hF;
            r_thousands <= 4'hF;
          end else begin
            r_units     <= r_scr[3:0];
            r_tens      <= r_scr[7:4];
            r_hundreds  <= r_scr[11:8];
            r_thousands <= r_scr[15:12];
          end
`else
          r_units     <= r_scr[3:0];
          r_tens      <= r_scr[7:4];
          r_hundreds  <= r_scr[11:8];
          r_thousands <= r_scr[15:12];
`endif
          r_ovf   <= r_ovf_next;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;
  assign units     = r_units;
  assign tens      = r_tens;
  assign hundreds  = r_hundreds;
  assign thousands = r_thousands;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bin_to_bcd_seq : directed and random checks of bin_to_bcd_seq         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bin_to_bcd_seq;

  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             busy;
  logic             done;
  logic [3:0]       units;
  logic [3:0]       tens;
  logic [3:0]       hundreds;
  logic [3:0]       thousands;
  logic             ovf;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int exp_done = 0;

  bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .units     (units),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  wire [15:0] digits = {thousands, hundreds, tens, units};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Called at a negedge; the following posedge accepts the request.
  task automatic issue(input int v);
    start  = 1'b1;
    bin_in = BIN_W'(v);
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Waits for done, checking latency, busy and digit hold; inj>0 pulses a stray start.
  task automatic finish(input string tag, input logic [15:0] exp_dig, input logic exp_ovf,
                        input int inj);
    int n;
    logic bad;
    logic [15:0] prev;
    n = 1;
    bad = 1'b0;
    prev = digits;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1 || digits !== prev) bad = 1'b1;
      @(negedge clk);
      n++;
      if (inj > 0 && n == inj) begin
        start  = 1'b1;
        bin_in = BIN_W'(5678);
      end
      if (inj > 0 && n == inj + 1) start = 1'b0;
    end
    exp_done++;
    chk({tag, ":latency"}, n, 16);
    chk({tag, ":hold"}, bad, 0);
    chk({tag, ":busy_end"}, busy, 0);
    chk({tag, ":digits"}, digits, exp_dig);
    chk({tag, ":ovf"}, ovf, exp_ovf);
  endtask

  initial begin
    logic [15:0] ovf_dig;
    int v;
`ifdef BCD_OVF_BLANK_EN
    ovf_dig = 16'hFFFF;
`else
    ovf_dig = 16'h6383;
`endif
    repeat (2) @(negedge clk);
    chk("rst_digits", digits, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done_cnt, 0);

    issue(1234);    finish("v1234", 16'h1234, 1'b0, 0);
    @(negedge clk);
    chk("done_width", done, 0);
    issue(9999);    finish("v9999", 16'h9999, 1'b0, 0);
    issue(0);       finish("v0", 16'h0000, 1'b0, 0);
    issue(10);      finish("v10", 16'h0010, 1'b0, 0);
    issue(16383);   finish("v16383", ovf_dig, 1'b1, 0);

    // Reset mid-conversion must clear everything and suppress the done pulse.
    issue(9999);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_digits", digits, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_nodone", done_cnt, exp_done);
    chk("midrst_busy_after", busy, 0);

    issue(4321);    finish("ignored_start", 16'h4321, 1'b0, 5);
    issue(5678);    finish("done_cycle_start", 16'h5678, 1'b0, 0);

    for (int i = 0; i < 2000; i++) begin
      v = int'($urandom_range(0, 9999));
      issue(v);
      finish($sformatf("sweep%0d_%0d", i, v), ref_bcd(v), 1'b0, 0);
    end
    @(negedge clk);
    chk("done_total", done_cnt, exp_done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble converter. Turns an unsigned binary value, such as a CPU register or PC selected for display, into four BCD digits.
- Sits directly upstream of the 4-digit seven-segment display driver. Its units/tens/hundreds/thousands outputs feed that driver's digit inputs.
- Digit outputs are registered and update atomically on conversion completion. The display never shows a partially converted value.

Parameters:
- BIN_W, 14, width of the binary input. Legal range 4..20.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  conversion request, sampled on rising clk edge
- bin_in  input  BIN_W  unsigned value to convert, captured when start is accepted
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when new digits are valid
- units  output  4  BCD digit 0 (least significant)
- tens  output  4  BCD digit 1
- hundreds  output  4  BCD digit 2
- thousands  output  4  BCD digit 3
- ovf  output  1  captured value exceeded 9999

Behaviour:
- Reset (asynchronous, any time, including mid-conversion):
  - state=IDLE, busy=0, done=0, ovf=0.
  - All four digits=0; the display shows 0000.
  - Internal shift/scratch registers and the iteration counter clear to 0.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - start=1 at edge N: bin_in is copied into the binary shift register and the 16-bit BCD scratch clears.
  - Iteration counter is set to BIN_W, next state is SHIFT, busy=1 after edge N.
  - ovf_next = (bin_in > 9999) is captured here.
  - start=0: remain in IDLE.
- SHIFT, one iteration per clk, edges N+1 .. N+BIN_W:
  - Each scratch nibble >= 5 gets +3 (all four nibbles evaluated in parallel, combinationally).
  - Then {scratch, binreg} shifts left by 1; the scratch MSB carried out of the thousands nibble is discarded.
  - Counter decrements. When the counter reaches 1 before decrement, next state is LOAD.
- LOAD, edge N+BIN_W+1:
  - Scratch nibbles are copied to units/tens/hundreds/thousands and ovf is updated.
  - done=1 for exactly this one cycle; busy=0; return to IDLE.
- Latency: done is high in the cycle following edge N+BIN_W+1, i.e. BIN_W+1 edges after start acceptance. For BIN_W=14 this is 15 cycles.
- start while busy (SHIFT/LOAD) is ignored, not queued. bin_in changes during conversion have no effect.
- start high in the cycle done is high: accepted, since the FSM is in IDLE. Back-to-back conversions have period BIN_W+2 cycles.
- Digit outputs hold their previous values through an entire conversion. They change only at the LOAD edge or on reset.
- Values above 9999: the truncated scratch yields value mod 10000 (lower four digits correct) and ovf=1.
- Width rule: if BIN_W <= 13, ovf is constant 0.
- Digits are always legal BCD (0..9) unless blanking is enabled; see Optional Feature.

Optional Feature:
- Macro: BCD_OVF_BLANK_EN.
- Defined: when ovf_next=1, LOAD writes 4'hF to all four digits instead of the mod-10000 result. The downstream driver's default segment pattern then blanks the display. ovf still asserts.
- Undefined: digits always show value mod 10000, with ovf as the only indication.

Test Plan:
- Reset then idle → digits 0/0/0/0, busy=0, done=0, ovf=0. Assert rst mid-SHIFT → same values on the next sample, no done pulse afterwards.
- start with bin_in=1234 (BIN_W=14) → busy for 15 cycles, done pulses once at edge N+15, thousands..units = 1/2/3/4, ovf=0. Digits unchanged (prior value) until that edge.
- bin_in=9999 → 9/9/9/9, ovf=0. bin_in=0 → 0/0/0/0. bin_in=10 → 0/0/1/0.
- bin_in=16383 (14'h3FFF):
  - Without macro → 6/3/8/3, ovf=1.
  - With BCD_OVF_BLANK_EN → F/F/F/F, ovf=1.
- Start 4321, pulse start with 5678 at cycle N+5 → ignored, result 4/3/2/1. Then start 5678 in the done cycle → accepted, 5/6/7/8 after a further 15 cycles.
- Random sweep of 2000 values in 0..9999 against a reference model (value/1000 %10, etc.) → all digits match, exactly one done per accepted start.
